// File: rtl/imuldiv_iter_unit.sv
// Iterative RV32M-style multiply/divide unit with val/rdy request and response streams.
// Optional IMULDIV_ITER_UNIT_EARLY_TERM_EN: multiplies leave CALC once the remaining multiplier bits are zero.
module imuldiv_iter_unit #(
  parameter int P_NBITS = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               istream_val,
  output logic               istream_rdy,
  input  logic [2:0]         istream_msg_op,
  input  logic [P_NBITS-1:0] istream_msg_a,
  input  logic [P_NBITS-1:0] istream_msg_b,
  output logic               ostream_val,
  input  logic               ostream_rdy,
  output logic [P_NBITS-1:0] ostream_msg
);
  localparam int N  = P_NBITS;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;

  logic [2:0]     op;
  logic           neg;
  logic [2*N-1:0] acc, mcand;
  logic [N-1:0]   mplier;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   result;

  // ---- accept-time decode ----
  logic         accept, a_sgn, b_sgn, neg_in, b_zero, ovf, special;
  logic [N-1:0] a_mag, b_mag, special_res;

  assign accept = istream_val && istream_rdy;
  assign a_sgn  = istream_msg_a[N-1] && (istream_msg_op inside {3'd1, 3'd3, 3'd4, 3'd6});
  assign b_sgn  = istream_msg_b[N-1] && (istream_msg_op inside {3'd1, 3'd4, 3'd6});
  assign a_mag  = a_sgn ? -istream_msg_a : istream_msg_a;
  assign b_mag  = b_sgn ? -istream_msg_b : istream_msg_b;
  // remainder takes the dividend's sign; everything else the product/quotient sign
  assign neg_in = (istream_msg_op inside {3'd6, 3'd7}) ? a_sgn : (a_sgn ^ b_sgn);

  assign b_zero  = (istream_msg_b == '0);
  assign ovf     = (istream_msg_op inside {3'd4, 3'd6}) &&
                   (istream_msg_a == {1'b1, {(N-1){1'b0}}}) && (istream_msg_b == '1);
  assign special = istream_msg_op[2] && (b_zero || ovf);
  always_comb begin
    special_res = '0;
    if (b_zero)
      special_res = istream_msg_op[1] ? istream_msg_a : '1;
    else
      special_res = istream_msg_op[1] ? '0 : istream_msg_a;
  end

  // ---- iteration datapath (divide reuses acc as remainder, mplier as dividend/quotient, mcand as divisor) ----
  logic [2*N-1:0] acc_add, prod;
  logic [N:0]     rem_sh, rem_nx;
  logic [N+1:0]   sub;
  logic           q_bit, last;
  logic [N-1:0]   quo_nx, calc_res;

  assign acc_add = mplier[0] ? acc + mcand : acc;
  assign rem_sh  = {acc[N-1:0], mplier[N-1]};
  assign sub     = {1'b0, rem_sh} - {2'b00, mcand[N-1:0]};
  assign q_bit   = ~sub[N+1];
  assign rem_nx  = q_bit ? sub[N:0] : rem_sh;
  assign quo_nx  = {mplier[N-2:0], q_bit};
  assign prod    = neg ? -acc_add : acc_add;

`ifdef IMULDIV_ITER_UNIT_EARLY_TERM_EN
  assign last = (cnt == CW'(N-1)) || (!op[2] && (mplier[N-1:1] == '0));
`else
  assign last = (cnt == CW'(N-1));
`endif

  always_comb begin
    calc_res = '0;
    case (op)
      3'd0:          calc_res = prod[N-1:0];
      3'd1, 3'd2,
      3'd3:          calc_res = prod[2*N-1:N];
      3'd4, 3'd5:    calc_res = neg ? -quo_nx : quo_nx;
      default:       calc_res = neg ? -rem_nx[N-1:0] : rem_nx[N-1:0];
    endcase
  end

  // ---- FSM ----
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = special ? DONE : CALC;
      CALC:    if (last) state_nx = DONE;
      DONE:    if (ostream_rdy) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    istream_rdy = (state == IDLE);
    ostream_val = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op <= '0; neg <= 1'b0; cnt <= '0; result <= '0;
      acc <= '0; mcand <= '0; mplier <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op  <= istream_msg_op;
          neg <= neg_in;
          cnt <= '0;
          acc <= '0;
          if (istream_msg_op[2]) begin
            mcand  <= {{N{1'b0}}, b_mag};
            mplier <= a_mag;
          end else begin
            mcand  <= {{N{1'b0}}, a_mag};
            mplier <= b_mag;
          end
          if (special) result <= special_res;
        end
        CALC: begin
          cnt <= cnt + CW'(1);
          if (op[2]) begin
            acc    <= {{(N-1){1'b0}}, rem_nx};
            mplier <= quo_nx;
          end else begin
            acc    <= acc_add;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
          if (last) result <= calc_res;
        end
        default: ;
      endcase
    end
  end

  assign ostream_msg = result;
endmodule
